// File: rtl/fsm_seq_pkg.sv
// Shared sizes, state encoding and program-entry layout for the step sequencer.
package fsm_seq_pkg;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One program entry: the a/b pair driven into the controlled FSM.
    typedef struct packed {
        logic a;
        logic b;
    } step_t;

endpackage

// File: rtl/seq_prog_mem.sv
// 8x2 program register file: synchronous write, combinational read, cleared on reset.
module seq_prog_mem
    import fsm_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  step_t            wdata,
    input  logic [IDX_W-1:0] raddr,
    output step_t            rdata
);

    step_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fsm_step_sequencer.sv
// Plays a stored a/b program into a controlled FSM, then captures its x/y outputs.
module fsm_step_sequencer
    import fsm_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [1:0]        wr_data,
    input  logic [LEN_W-1:0]  len,
    input  logic              start,
    input  logic              abort,
    output logic              a,
    output logic              b,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] y_in,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  step_idx,
    output logic [DATA_W-1:0] x_last,
    output logic [DATA_W-1:0] y_last
);

    state_t             state;
    state_t             state_n;
    logic [IDX_W-1:0]   idx_n;
    logic [LEN_W-1:0]   len_eff;
    logic [LEN_W-1:0]   len_eff_n;
    step_t              ab_q;
    step_t              ab_n;
    step_t              rd_data;
    logic               prog_we_c;
    logic               capture_c;

    assign prog_we_c = wr_en && (state == IDLE);

    seq_prog_mem u_prog_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (prog_we_c),
        .waddr (wr_addr),
        .wdata (step_t'(wr_data)),
        .raddr (idx_n),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = step_idx;
        len_eff_n = len_eff;
        capture_c = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    len_eff_n = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
                    idx_n     = '0;
                    state_n   = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (step_idx == IDX_W'(len_eff - LEN_W'(1))) begin
                    state_n = FLUSH;
                end else begin
                    idx_n = step_idx + IDX_W'(1);
                end
            end
            FLUSH: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    state_n   = DONE;
                    capture_c = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // A write landing in the start cycle must reach the first driven step.
    assign ab_n = (state_n != RUN) ? '0 :
                  (prog_we_c && (wr_addr == idx_n)) ? step_t'(wr_data) : rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_idx <= '0;
            len_eff  <= '0;
            ab_q     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            x_last   <= '0;
            y_last   <= '0;
        end else begin
            step_idx <= idx_n;
            len_eff  <= len_eff_n;
            ab_q     <= ab_n;
            busy     <= (state_n == RUN) || (state_n == FLUSH);
            done     <= (state_n == DONE);
            if (capture_c) begin
                x_last <= x_in;
                y_last <= y_in;
            end
        end
    end

    assign a = ab_q.a;
    assign b = ab_q.b;

endmodule
